// File: rtl/exp_ro_sequencer.sv
// Frame sequencer: runs NUM_SUBF masked exposures, then one row readout, per frame.
// Single-shot or continuous operation, with a frame counter and a sticky readout-timeout flag.
module exp_ro_sequencer #(
  parameter int SUBF_W  = 8,
  parameter int FRAME_W = 16,
  parameter int RO_TO   = 64
) (
  input  logic               CLK,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               continuous,
  input  logic [SUBF_W-1:0]  NUM_SUBF,
  output logic               mask_req,
  input  logic               mask_ack,
  output logic               exp_start,
  input  logic               exp_busy,
  output logic               trigger_o,
  input  logic               re_busy,
  output logic [SUBF_W-1:0]  subf_idx,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic               busy,
  output logic               ro_timeout,
  output logic [2:0]         state_o
);

  localparam int CNT_W = $clog2(RO_TO + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MASK      = 3'd1,
    EXP_GO    = 3'd2,
    EXP_WAIT  = 3'd3,
    RO_GO     = 3'd4,
    RO_ACK    = 3'd5,
    RO_WAIT   = 3'd6,
    FRAME_END = 3'd7
  } state_t;

  state_t             state_r, state_s;
  logic [SUBF_W-1:0]  nsub_r, nsub_s;
  logic [SUBF_W-1:0]  subf_s;
  logic [FRAME_W-1:0] frame_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic               seen_r, seen_s;
  logic               stop_pend_r, stop_pend_s;
  logic               tout_s;

  // Next-state and next-datapath logic.
  always_comb begin
    state_s     = state_r;
    nsub_s      = nsub_r;
    subf_s      = subf_idx;
    frame_s     = frame_cnt;
    cnt_s       = cnt_r;
    seen_s      = seen_r;
    tout_s      = ro_timeout;
    stop_pend_s = stop_pend_r | (stop & (state_r != IDLE));
    case (state_r)
      IDLE: begin
        stop_pend_s = 1'b0;
        if (start) begin
          state_s = MASK;
          nsub_s  = (NUM_SUBF == {SUBF_W{1'b0}}) ? SUBF_W'(1) : NUM_SUBF;
          subf_s  = {SUBF_W{1'b0}};
          frame_s = {FRAME_W{1'b0}};
          tout_s  = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      MASK: begin
        if (mask_ack) state_s = EXP_GO;
        else          state_s = MASK;
      end
      EXP_GO: begin
        state_s = EXP_WAIT;
        seen_s  = 1'b0;
      end
      EXP_WAIT: begin
        // Completion needs a busy-high sample first, so a slow-to-respond engine is not mistaken for done.
        if (seen_r && !exp_busy) begin
          seen_s = 1'b0;
          if (subf_idx == nsub_r - SUBF_W'(1)) begin
            state_s = RO_GO;
          end else begin
            subf_s  = subf_idx + SUBF_W'(1);
            state_s = MASK;
          end
        end else begin
          seen_s = seen_r | exp_busy;
        end
      end
      RO_GO: begin
        cnt_s   = CNT_W'(RO_TO);
        state_s = RO_ACK;
      end
      RO_ACK: begin
        // re_busy is checked first so it wins over an expiring counter.
        if (re_busy) begin
          state_s = RO_WAIT;
        end else if (cnt_r <= CNT_W'(1)) begin
          cnt_s   = {CNT_W{1'b0}};
          tout_s  = 1'b1;
          state_s = FRAME_END;
        end else begin
          cnt_s = cnt_r - CNT_W'(1);
        end
      end
      RO_WAIT: begin
        if (!re_busy) state_s = FRAME_END;
        else          state_s = RO_WAIT;
      end
      FRAME_END: begin
        frame_s = frame_cnt + FRAME_W'(1);
        subf_s  = {SUBF_W{1'b0}};
        if (continuous && !stop_pend_r && !stop) begin
          state_s = MASK;
        end else begin
          state_s     = IDLE;
          stop_pend_s = 1'b0;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_r     <= IDLE;
      nsub_r      <= {SUBF_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      seen_r      <= 1'b0;
      stop_pend_r <= 1'b0;
      subf_idx    <= {SUBF_W{1'b0}};
      frame_cnt   <= {FRAME_W{1'b0}};
      ro_timeout  <= 1'b0;
      mask_req    <= 1'b0;
      exp_start   <= 1'b0;
      trigger_o   <= 1'b0;
      busy        <= 1'b0;
      state_o     <= 3'd0;
    end else begin
      state_r     <= state_s;
      nsub_r      <= nsub_s;
      cnt_r       <= cnt_s;
      seen_r      <= seen_s;
      stop_pend_r <= stop_pend_s;
      subf_idx    <= subf_s;
      frame_cnt   <= frame_s;
      ro_timeout  <= tout_s;
      mask_req    <= (state_s == MASK);
      exp_start   <= (state_s == EXP_GO);
      trigger_o   <= (state_s == RO_GO);
      busy        <= (state_s != IDLE);
      state_o     <= state_s;
    end
  end

endmodule

// File: tb/tb_exp_ro_sequencer.sv
// Scoreboard bench for exp_ro_sequencer: exposure/readout/mask responders plus
// queues of expected subf_idx per exp_start and frame_cnt per trigger_o.
module tb_exp_ro_sequencer;

  localparam int SUBF_W  = 8;
  localparam int FRAME_W = 4;

  logic               CLK = 1'b0;
  logic               rst, start, stop, continuous;
  logic [SUBF_W-1:0]  NUM_SUBF;
  logic               mask_req, mask_ack, exp_start, exp_busy;
  logic               trigger_o, re_busy, busy, ro_timeout;
  logic [SUBF_W-1:0]  subf_idx;
  logic [FRAME_W-1:0] frame_cnt;
  logic [2:0]         state_o;

  exp_ro_sequencer #(.SUBF_W(SUBF_W), .FRAME_W(FRAME_W), .RO_TO(64)) dut (
    .CLK(CLK), .rst(rst), .start(start), .stop(stop), .continuous(continuous),
    .NUM_SUBF(NUM_SUBF), .mask_req(mask_req), .mask_ack(mask_ack),
    .exp_start(exp_start), .exp_busy(exp_busy), .trigger_o(trigger_o),
    .re_busy(re_busy), .subf_idx(subf_idx), .frame_cnt(frame_cnt),
    .busy(busy), .ro_timeout(ro_timeout), .state_o(state_o)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];
  int trig_q[$];
  int cyc = 0, exp_cnt = 0, trig_cnt = 0;
  int trig_cyc = 0, tout_cyc = -1, tout_state = -1;
  int mreq_run = 0, last_mreq_run = 0;
  int ack_delay = 0, mcnt = 0;
  logic ro_dead = 1'b0;
  logic prev_ack = 1'b0, exp_prev_ack = 1'b0, prev_tout = 1'b0, exp_tout = 1'b0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Exposure engine: busy for 10 cycles after each exp_start.
  initial begin
    exp_busy = 1'b0;
    forever begin
      @(negedge CLK);
      if (exp_start) begin
        exp_busy = 1'b1;
        repeat (10) @(negedge CLK);
        exp_busy = 1'b0;
      end
    end
  end

  // Readout engine: busy for 20 cycles after trigger_o unless ro_dead.
  initial begin
    re_busy = 1'b0;
    forever begin
      @(negedge CLK);
      if (trigger_o && !ro_dead) begin
        re_busy = 1'b1;
        repeat (20) @(negedge CLK);
        re_busy = 1'b0;
      end
    end
  end

  // Mask loader: tied high when ack_delay==0, else one-cycle ack on the ack_delay-th request cycle.
  initial begin
    mask_ack = 1'b1;
    forever begin
      @(negedge CLK);
      if (ack_delay == 0) begin
        mask_ack = 1'b1;
      end else if (mask_ack) begin
        mask_ack = 1'b0;
        mcnt = 0;
      end else if (mask_req) begin
        mcnt++;
        if (mcnt == ack_delay) mask_ack = 1'b1;
      end else begin
        mcnt = 0;
      end
    end
  end

  // Output monitor and scoreboard comparison.
  initial begin
    forever begin
      @(negedge CLK);
      cyc++;
      if (exp_start) begin
        exp_cnt++;
        exp_prev_ack = prev_ack;
        exp_tout = ro_timeout;
        if (exp_q.size() == 0) chk("exp_start_unexpected", exp_q.size(), 1);
        else chk("exp_subf_idx", int'(subf_idx), exp_q.pop_front());
      end
      if (trigger_o) begin
        trig_cnt++;
        trig_cyc = cyc;
        if (trig_q.size() == 0) chk("trigger_unexpected", trig_q.size(), 1);
        else chk("trig_frame_cnt", int'(frame_cnt), trig_q.pop_front());
      end
      if (ro_timeout && !prev_tout) begin
        tout_cyc = cyc;
        tout_state = int'(state_o);
      end
      if (mask_req) mreq_run++;
      else if (mreq_run > 0) begin
        last_mreq_run = mreq_run;
        mreq_run = 0;
      end
      prev_ack = mask_ack;
      prev_tout = ro_timeout;
    end
  end

  task automatic start_frame(input int n, input logic cont);
    @(negedge CLK);
    NUM_SUBF = SUBF_W'(n);
    continuous = cont;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge CLK);
    stop = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      if (!busy) break;
      @(negedge CLK);
    end
    if (busy) chk(tag, int'(busy), 0);
  endtask

  task automatic wait_trig(input int target, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      if (trig_cnt >= target) break;
      @(negedge CLK);
    end
    if (trig_cnt < target) chk(tag, trig_cnt, target);
  endtask

  initial begin
    int base_e, base_t;
    rst = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0; NUM_SUBF = '0;
    repeat (3) @(negedge CLK);
    chk("rst_state", int'(state_o), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_mask_req", int'(mask_req), 0);
    rst = 1'b0;
    repeat (2) @(negedge CLK);

    // Single frame, 3 subframes, with start latency checks.
    base_e = exp_cnt; base_t = trig_cnt;
    exp_q = '{0, 1, 2}; trig_q = '{0};
    start_frame(3, 1'b0);
    chk("lat_mask_req", int'(mask_req), 1);
    @(negedge CLK);
    chk("lat_exp_start", int'(exp_start), 1);
    wait_idle(400, "single_idle_wait");
    chk("single_exp_cnt", exp_cnt - base_e, 3);
    chk("single_trig_cnt", trig_cnt - base_t, 1);
    chk("single_frame_cnt", int'(frame_cnt), 1);
    chk("single_state", int'(state_o), 0);
    chk("single_q_empty", exp_q.size() + trig_q.size(), 0);

    // Continuous, stop during the 2nd frame's RO_WAIT.
    base_e = exp_cnt; base_t = trig_cnt;
    exp_q = '{0, 0}; trig_q = '{0, 1};
    start_frame(1, 1'b1);
    wait_trig(base_t + 2, 300, "stop_trig_wait");
    for (int i = 0; i < 50; i++) begin
      if (state_o == 3'd6) break;
      @(negedge CLK);
    end
    chk("stop_in_ro_wait", int'(state_o), 6);
    pulse_stop();
    wait_idle(200, "stop_idle_wait");
    repeat (20) @(negedge CLK);
    chk("stop_frame_cnt", int'(frame_cnt), 2);
    chk("stop_exp_cnt", exp_cnt - base_e, 2);
    chk("stop_q_empty", exp_q.size() + trig_q.size(), 0);

    // Readout never responds: timeout latency, persistence, clear on start.
    ro_dead = 1'b1; tout_cyc = -1;
    exp_q = '{0, 0}; trig_q = '{0, 1};
    start_frame(1, 1'b1);
    wait_trig(trig_cnt + 1, 100, "tout_trig_wait");
    base_t = trig_cnt;
    for (int i = 0; i < 120; i++) begin
      if (tout_cyc >= 0) break;
      @(negedge CLK);
    end
    chk("tout_latency", tout_cyc - trig_cyc, 65);
    chk("tout_state_frame_end", tout_state, 7);
    wait_trig(base_t + 1, 200, "tout_trig2_wait");
    chk("tout_persist_next_frame", int'(exp_tout), 1);
    pulse_stop();
    wait_idle(200, "tout_idle_wait");
    chk("tout_sticky_idle", int'(ro_timeout), 1);
    ro_dead = 1'b0;
    exp_q = '{0}; trig_q = '{0};
    start_frame(1, 1'b0);
    chk("tout_clear_on_start", int'(ro_timeout), 0);
    wait_idle(200, "tout_clean_idle_wait");
    chk("tout_clean_frame", int'(ro_timeout), 0);

    // NUM_SUBF=0 acts as 1; mask_ack delayed 7 cycles.
    ack_delay = 7;
    base_e = exp_cnt; base_t = trig_cnt;
    exp_q = '{0}; trig_q = '{0};
    start_frame(0, 1'b0);
    wait_idle(300, "nsub0_idle_wait");
    chk("nsub0_exp_cnt", exp_cnt - base_e, 1);
    chk("nsub0_trig_cnt", trig_cnt - base_t, 1);
    chk("nsub0_mask_req_len", last_mreq_run, 7);
    chk("nsub0_exp_after_ack", int'(exp_prev_ack), 1);
    ack_delay = 0;

    // Reset in EXP_WAIT of subframe 1.
    base_t = trig_cnt;
    exp_q = '{0, 1}; trig_q = '{};
    start_frame(3, 1'b0);
    for (int i = 0; i < 100; i++) begin
      if (subf_idx == 8'd1 && state_o == 3'd3) break;
      @(negedge CLK);
    end
    chk("rst_mid_reached", int'(state_o), 3);
    rst = 1'b1;
    @(negedge CLK);
    rst = 1'b0;
    chk("rstmid_outputs", int'({mask_req, exp_start, trigger_o, busy, ro_timeout}), 0);
    chk("rstmid_subf_idx", int'(subf_idx), 0);
    chk("rstmid_frame_cnt", int'(frame_cnt), 0);
    chk("rstmid_state", int'(state_o), 0);
    repeat (30) @(negedge CLK);
    chk("rstmid_no_trigger", trig_cnt - base_t, 0);
    chk("rstmid_q_empty", exp_q.size(), 0);
    exp_q = '{0, 1}; trig_q = '{0};
    start_frame(2, 1'b0);
    wait_idle(300, "rstmid_clean_idle_wait");
    chk("rstmid_clean_frame_cnt", int'(frame_cnt), 1);

    // 16 continuous frames: frame_cnt wraps 15 -> 0; start while busy ignored.
    base_t = trig_cnt;
    exp_q = '{}; trig_q = '{};
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(0);
      trig_q.push_back(i);
    end
    start_frame(1, 1'b1);
    wait_trig(base_t + 3, 400, "wrap_trig3_wait");
    start_frame(5, 1'b1);
    wait_trig(base_t + 16, 2000, "wrap_trig16_wait");
    pulse_stop();
    wait_idle(200, "wrap_idle_wait");
    chk("wrap_frame_cnt", int'(frame_cnt), 0);
    chk("wrap_trig_cnt", trig_cnt - base_t, 16);
    chk("wrap_q_empty", exp_q.size() + trig_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/exp_ro_sequencer.md
Name: exp_ro_sequencer

Overview:
- Frame-level controller that sequences the coded-exposure engine and the row readout engine.
- Per frame: runs NUM_SUBF subframes of (mask load handshake → exposure pulse → wait for exposure complete), then fires one readout trigger and waits out re_busy.
- Sits above the exposure module and the readout module. Runs single-shot or continuous, and counts completed frames.

Parameters:
- SUBF_W, 8, width of subframe count and index.
- FRAME_W, 16, width of frame counter (wraps).
- RO_TO, 64, cycles allowed between trigger_o and re_busy rising before timeout.

Ports:
- CLK  in  1  system clock (200 MHz domain).
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle request to begin; honoured only in IDLE.
- stop  in  1  one-cycle request to halt after the current frame completes.
- continuous  in  1  1 = loop frames; 0 = single frame. Sampled at FRAME_END.
- NUM_SUBF  in  SUBF_W  subframes per frame. Latched on accepted start; 0 is treated as 1.
- mask_req  out  1  request mask pattern load for the next subframe.
- mask_ack  in  1  mask loader done.
- exp_start  out  1  one-cycle pulse to the exposure engine.
- exp_busy  in  1  exposure engine active.
- trigger_o  out  1  one-cycle readout trigger.
- re_busy  in  1  readout engine active.
- subf_idx  out  SUBF_W  current subframe index, 0-based.
- frame_cnt  out  FRAME_W  completed frames.
- busy  out  1  high in every state except IDLE.
- ro_timeout  out  1  sticky: re_busy never rose within RO_TO cycles.
- state_o  out  3  current state encoding.

Behaviour:
- All outputs are registered. On rst, every output is 0 and the state is IDLE; rst mid-frame aborts immediately, with no trigger_o or exp_start emitted.
- State encoding: IDLE=0, MASK=1, EXP_GO=2, EXP_WAIT=3, RO_GO=4, RO_ACK=5, RO_WAIT=6, FRAME_END=7.
- IDLE: start=1 → MASK next cycle. On this transition:
  - latch nsub = (NUM_SUBF==0 ? 1 : NUM_SUBF);
  - clear subf_idx, frame_cnt, ro_timeout and stop_pending.
  - stop is ignored in IDLE.
- MASK: mask_req=1 while in state.
  - mask_ack sampled high → EXP_GO; mask_req is 0 the following cycle.
  - mask_ack already high on MASK entry is accepted on the first cycle.
- EXP_GO: exp_start=1 for exactly this one cycle → EXP_WAIT.
- EXP_WAIT: set internal seen flag when exp_busy is sampled high. Exposure done = seen && !exp_busy.
  - On done, if subf_idx==nsub-1 → RO_GO.
  - Otherwise subf_idx+1 → MASK.
  - The seen flag clears on exit.
- RO_GO: trigger_o=1 for exactly one cycle → RO_ACK; load the timeout counter with RO_TO.
- RO_ACK:
  - re_busy high → RO_WAIT.
  - Counter reaches 0 before that → set ro_timeout → FRAME_END.
  - re_busy high on the same cycle the counter hits 0: re_busy wins, no timeout.
- RO_WAIT: re_busy low → FRAME_END. No timeout applies here.
- FRAME_END: frame_cnt+1 (wraps 2^FRAME_W-1 → 0); subf_idx ← 0.
  - continuous && !stop_pending → MASK.
  - Otherwise → IDLE.
- stop=1 in any non-IDLE state sets stop_pending.
  - The current frame always completes.
  - stop_pending clears on entry to IDLE.
  - stop and start together in IDLE: start wins and stop is discarded.
- start while busy is ignored. NUM_SUBF changes mid-run have no effect until the next accepted start.
- ro_timeout stays set through subsequent frames; it clears only on rst or an accepted start.
- Latency, start sampled at cycle k:
  - mask_req=1 at k+1;
  - with mask_ack tied high, exp_start at k+2.

Test Plan:
- Single frame, NUM_SUBF=3, mask_ack tied 1, exposure model busy 10 cycles after exp_start, readout model busy 20 cycles after trigger_o → 3 exp_start pulses, subf_idx 0,1,2, one trigger_o, frame_cnt=1, return to IDLE, busy=0.
- Continuous, NUM_SUBF=1, stop pulsed during the 2nd frame's RO_WAIT → frame_cnt=2 at IDLE; no further exp_start after the 2nd trigger_o.
- Readout engine never raises re_busy, RO_TO=64 → ro_timeout=1 exactly 65 cycles after the trigger_o cycle; FRAME_END reached; flag persists into the next frame and clears on the next start.
- NUM_SUBF=0 → behaves as 1: one exp_start per trigger_o. mask_ack delayed 7 cycles → mask_req high 7 cycles, exp_start one cycle after ack.
- rst asserted in EXP_WAIT of subframe 1 → next cycle all outputs 0, state_o=0; no trigger_o emitted; subsequent start runs a clean frame.
- frame_cnt preloaded near wrap (FRAME_W=4, 16 continuous frames) → reads 15 then 0; start pulsed while busy has no effect.
